dmem_responder: RTL and testbench

Data-memory responder for the RISC toy pipeline: the memory-side end of the active-low `DREQ`/`DRW` data-access interface driven by the core's decode stage. It accepts one load or store request per strobe, commits stores into an internal word-addressed array, and returns load data with a registered `DRDY` pulse. An optional wait-state engine stalls the core through `DBUSY` so slow memory can be modelled.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and encodings for the data-memory access interface.
// Imported by the responder and by the decode stage that drives DREQ/DRW.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic DRW_LOAD  = 1'b0;
  localparam logic DRW_STORE = 1'b1;
  localparam logic DREQ_ON   = 1'b0;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: data-access bus between the core (master) and the
// data memory (slave). DREQ is an active-low strobe; DRDY is a one-cycle
// completion pulse, DERR is qualified by DRDY.
interface dmem_responder_if;

  logic        DREQ;
  logic        DRW;
  logic [31:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  logic        DRDY;
  logic        DBUSY;
  logic        DERR;

  modport master (
    output DREQ, DRW, DADDR, DWDATA,
    input  DRDATA, DRDY, DBUSY, DERR
  );

  modport slave (
    input  DREQ, DRW, DADDR, DWDATA,
    output DRDATA, DRDY, DBUSY, DERR
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous RAM, 2^ADDR_W x 32.
// The read register only updates when re is high, so it holds the last
// loaded word across stores and idle cycles. A read and write to the same
// word on one edge returns the old contents. Contents are never reset.
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Next read value: fetch the addressed word on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // Storage write port and read register.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the DREQ/DRW data-access interface.
// Accepts one load/store per strobe in IDLE or RESP, commits or reads the
// array on the accept edge, and pulses DRDY in RESP.
// Optional wait-state engine selected by macro DMEM_STALL_EN: adds the WAIT
// state and a 4-bit down-counter preset to WAIT_CYC-1; without it DBUSY is 0
// and WAIT_CYC is ignored.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input logic             CLK,
  input logic             RST,
  dmem_responder_if.slave bus
);

  dmem_state_t       state_q, state_d;
  logic              err_q, err_d;
  logic              zero_q, zero_d;
  logic              accept;
  logic              addr_err;
  logic [ADDR_W-1:0] widx;
  logic              ram_we;
  logic              ram_re;
  logic [31:0]       ram_rdata;
  logic              drdy;
  logic              dbusy;
  logic              derr;

`ifdef DMEM_STALL_EN
  logic [3:0] cnt_q, cnt_d;
`else
  logic unused_wait_cyc;
  assign unused_wait_cyc = (WAIT_CYC != 0);
`endif

  assign widx     = bus.DADDR[ADDR_W+1:2];
  assign addr_err = (bus.DADDR[1:0] != 2'b00) || ((bus.DADDR >> (ADDR_W + 2)) != 32'd0);
  assign accept   = ((state_q == IDLE) || (state_q == RESP)) && (bus.DREQ == DREQ_ON);
  assign ram_we   = accept && (bus.DRW == DRW_STORE) && !addr_err;
  assign ram_re   = accept && (bus.DRW == DRW_LOAD) && !addr_err;

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (CLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (widx),
    .wdata (bus.DWDATA),
    .rdata (ram_rdata)
  );

  // Error flag and DRDATA zero-override: an errored access forces DRDATA
  // to 0 without touching the array; a good load releases the override.
  always_comb begin
    err_d  = err_q;
    zero_d = zero_q;
    if (accept) begin
      err_d = addr_err;
      if (addr_err)    zero_d = 1'b1;
      else if (ram_re) zero_d = 1'b0;
    end
  end

  // State register, wait counter and access-status flops.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
`ifdef DMEM_STALL_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
`ifdef DMEM_STALL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic: accept from IDLE/RESP, count down through WAIT.
  always_comb begin
    state_d = state_q;
`ifdef DMEM_STALL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
`ifdef DMEM_STALL_EN
          if (WAIT_CYC == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYC - 1);
          end
`else
          state_d = RESP;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
`ifdef DMEM_STALL_EN
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: DRDY for the RESP cycle, DBUSY while waiting.
  always_comb begin
    drdy  = (state_q == RESP);
`ifdef DMEM_STALL_EN
    dbusy = (state_q == WAIT);
`else
    dbusy = 1'b0;
`endif
    derr  = drdy && err_q;
  end

  assign bus.DRDY   = drdy;
  assign bus.DBUSY  = dbusy;
  assign bus.DERR   = derr;
  assign bus.DRDATA = zero_q ? 32'd0 : ram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven single-cycle vectors
// for the default build, hand-written multi-cycle sequences for the
// wait-state build and for reset during an access.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int WAIT_CYC = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC(WAIT_CYC)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rdy;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic rw, input logic [31:0] a, input logic [31:0] d);
    bus.DREQ   = req;
    bus.DRW    = rw;
    bus.DADDR  = a;
    bus.DWDATA = d;
  endtask

  task automatic idle();
    drive(~DREQ_ON, DRW_LOAD, 32'd0, 32'd0);
  endtask

  task automatic stall_access(input string nm, input logic rw, input logic [31:0] a,
                              input logic [31:0] d, input logic exp_err,
                              input logic [31:0] exp_data, input logic drop);
    drive(DREQ_ON, rw, a, d);
    @(posedge clk); #1;
    idle();
    for (int i = 0; i < WAIT_CYC; i++) begin
      chk({nm, " busy"}, {31'd0, bus.DBUSY}, 32'd1);
      chk({nm, " early_rdy"}, {31'd0, bus.DRDY}, 32'd0);
      if (drop && i == 0) drive(DREQ_ON, DRW_STORE, 32'h10, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      idle();
    end
    chk({nm, " rdy"}, {31'd0, bus.DRDY}, 32'd1);
    chk({nm, " busy_end"}, {31'd0, bus.DBUSY}, 32'd0);
    chk({nm, " err"}, {31'd0, bus.DERR}, {31'd0, exp_err});
    chk({nm, " data"}, bus.DRDATA, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{DREQ_ON,  DRW_STORE, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000};
    vt[1]  = '{DREQ_ON,  DRW_LOAD,  32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[2]  = '{~DREQ_ON, DRW_LOAD,  32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF};
    vt[3]  = '{DREQ_ON,  DRW_STORE, 32'h0000_0000, 32'h1111_1111, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[4]  = '{DREQ_ON,  DRW_STORE, 32'h0000_0004, 32'h2222_2222, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[5]  = '{DREQ_ON,  DRW_STORE, 32'h0000_0008, 32'h3333_3333, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[6]  = '{DREQ_ON,  DRW_STORE, 32'h0000_000C, 32'h4444_4444, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[7]  = '{DREQ_ON,  DRW_LOAD,  32'h0000_0000, 32'h0,         1'b1, 1'b0, 32'h1111_1111};
    vt[8]  = '{DREQ_ON,  DRW_LOAD,  32'h0000_0004, 32'h0,         1'b1, 1'b0, 32'h2222_2222};
    vt[9]  = '{DREQ_ON,  DRW_LOAD,  32'h0000_0008, 32'h0,         1'b1, 1'b0, 32'h3333_3333};
    vt[10] = '{DREQ_ON,  DRW_LOAD,  32'h0000_000C, 32'h0,         1'b1, 1'b0, 32'h4444_4444};
    vt[11] = '{DREQ_ON,  DRW_LOAD,  32'h0000_0013, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vt[12] = '{DREQ_ON,  DRW_LOAD,  32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[13] = '{DREQ_ON,  DRW_STORE, 32'h0000_1000, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'h0000_0000};
    vt[14] = '{DREQ_ON,  DRW_LOAD,  32'h0000_0000, 32'h0,         1'b1, 1'b0, 32'h1111_1111};
    vt[15] = '{DREQ_ON,  DRW_STORE, 32'h0000_0012, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_0000};
    vt[16] = '{DREQ_ON,  DRW_LOAD,  32'h0000_0010, 32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[17] = '{DREQ_ON,  DRW_STORE, 32'h0000_0FFC, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[18] = '{DREQ_ON,  DRW_LOAD,  32'h0000_0FFC, 32'h0,         1'b1, 1'b0, 32'hA5A5_A5A5};
    vt[19] = '{DREQ_ON,  DRW_LOAD,  32'h8000_0010, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    vt[20] = '{~DREQ_ON, DRW_LOAD,  32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0000_0000};
    vt[21] = '{~DREQ_ON, DRW_STORE, 32'h0000_0010, 32'h9999_9999, 1'b0, 1'b0, 32'h0000_0000};
    vt[22] = '{DREQ_ON,  DRW_STORE, 32'h0000_0008, 32'h6666_6666, 1'b1, 1'b0, 32'h0000_0000};
    vt[23] = '{DREQ_ON,  DRW_LOAD,  32'h0000_0008, 32'h0,         1'b1, 1'b0, 32'h6666_6666};
    vt[24] = '{~DREQ_ON, DRW_LOAD,  32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h6666_6666};

    rst = 1'b1;
    idle();
    #12;
    chk("reset drdy",   {31'd0, bus.DRDY},  32'd0);
    chk("reset dbusy",  {31'd0, bus.DBUSY}, 32'd0);
    chk("reset derr",   {31'd0, bus.DERR},  32'd0);
    chk("reset drdata", bus.DRDATA,         32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifndef DMEM_STALL_EN
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].req, vt[i].rw, vt[i].addr, vt[i].wdata);
      @(posedge clk); #1;
      chk($sformatf("vec%0d drdy", i),   {31'd0, bus.DRDY},  {31'd0, vt[i].exp_rdy});
      chk($sformatf("vec%0d derr", i),   {31'd0, bus.DERR},  {31'd0, vt[i].exp_err});
      chk($sformatf("vec%0d dbusy", i),  {31'd0, bus.DBUSY}, 32'd0);
      chk($sformatf("vec%0d drdata", i), bus.DRDATA,         vt[i].exp_data);
    end

    // reset while the response of a store is on the bus
    drive(DREQ_ON, DRW_STORE, 32'h20, 32'h1234);
    @(posedge clk); #1;
    chk("rstmid store rdy", {31'd0, bus.DRDY}, 32'd1);
    drive(DREQ_ON, DRW_LOAD, 32'h20, 32'h0);
    rst = 1'b1;
    #1;
    chk("rstmid drdy",   {31'd0, bus.DRDY}, 32'd0);
    chk("rstmid derr",   {31'd0, bus.DERR}, 32'd0);
    chk("rstmid drdata", bus.DRDATA,        32'd0);
    @(posedge clk); #1;
    chk("rstheld drdy",  {31'd0, bus.DRDY}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    idle();
    chk("post-rst load rdy",  {31'd0, bus.DRDY}, 32'd1);
    chk("post-rst load data", bus.DRDATA,        32'h0000_1234);
    @(posedge clk); #1;
    chk("post-rst idle rdy",  {31'd0, bus.DRDY}, 32'd0);
`else
    stall_access("st0",    DRW_STORE, 32'h00,   32'h1111_1111, 1'b0, 32'h0,         1'b0);
    stall_access("st10",   DRW_STORE, 32'h10,   32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0);
    stall_access("ld10d",  DRW_LOAD,  32'h10,   32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1);
    stall_access("ld10",   DRW_LOAD,  32'h10,   32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0);
    stall_access("ld13",   DRW_LOAD,  32'h13,   32'h0,         1'b1, 32'h0,         1'b0);
    stall_access("st1000", DRW_STORE, 32'h1000, 32'hBAD0_BAD0, 1'b1, 32'h0,         1'b0);
    stall_access("ld0",    DRW_LOAD,  32'h00,   32'h0,         1'b0, 32'h1111_1111, 1'b0);
    @(posedge clk); #1;

    // reset during the WAIT phase of a store
    drive(DREQ_ON, DRW_STORE, 32'h20, 32'h1234);
    @(posedge clk); #1;
    idle();
    chk("rstmid busy before", {31'd0, bus.DBUSY}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid busy",   {31'd0, bus.DBUSY}, 32'd0);
    chk("rstmid drdy",   {31'd0, bus.DRDY},  32'd0);
    chk("rstmid drdata", bus.DRDATA,         32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < WAIT_CYC + 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post-rst quiet%0d", i), {31'd0, bus.DRDY}, 32'd0);
    end
    stall_access("ld20", DRW_LOAD, 32'h20, 32'h0, 1'b0, 32'h0000_1234, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
